// File: rtl/eth_wb_arbiter.sv
// eth_wb_arbiter: two-master round-robin Wishbone arbiter in front of the shared
// Ethernet slave. A granted master keeps the bus until it drops cyc, and the
// grant passes straight to a waiting master with no idle gap.
// Optional stall watchdog: define ETH_WB_ARB_TIMEOUT_EN to build a 10-bit
// counter that returns a one-cycle error when the slave stalls TIMEOUT_CYC cycles.

module eth_wb_arbiter #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [9:0]  m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [9:0]  m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [9:0]  s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    output logic [1:0]  gnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_stateNext;
    logic       r_last;
    logic       w_lastNext;
    logic [1:0] r_gnt;
    logic [1:0] w_gntNext;
    logic       w_toErr;

    // The counter is 10 bits wide, so a limit outside 1..1023 can never be reached.
    generate
        if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 1023) begin : g_badTimeout
            $error("eth_wb_arbiter: TIMEOUT_CYC must lie in 1..1023");
        end
    endgenerate

    // Next-state arbitration: round robin from IDLE, no preemption, and direct handoff on release.
    always_comb begin
        w_stateNext = r_state;
        w_lastNext  = r_last;
        w_gntNext   = 2'b00;
        case (r_state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    w_stateNext = r_last ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    w_stateNext = GNT0;
                end else if (m1_cyc_i) begin
                    w_stateNext = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    w_lastNext  = 1'b0;
                    w_stateNext = m1_cyc_i ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    w_lastNext  = 1'b1;
                    w_stateNext = m0_cyc_i ? GNT0 : IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
        case (w_stateNext)
            GNT0:    w_gntNext = 2'b01;
            GNT1:    w_gntNext = 2'b10;
            default: w_gntNext = 2'b00;
        endcase
    end

    // State, last-granted master and registered one-hot grant.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_gnt   <= 2'b00;
        end else begin
            r_state <= w_stateNext;
            r_last  <= w_lastNext;
            r_gnt   <= w_gntNext;
        end
    end

    assign gnt_o = r_gnt;

`ifdef ETH_WB_ARB_TIMEOUT_EN
    localparam logic [9:0] TO_LIMIT = 10'(TIMEOUT_CYC);

    logic [9:0] r_toCnt;

    assign w_toErr = (r_toCnt == TO_LIMIT);

    // Count stalled strobe cycles; restart on any slave response, on a fired timeout or when the grant moves.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_toCnt <= 10'd0;
        end else if ((w_stateNext != r_state) || s_ack_i || s_err_i || w_toErr) begin
            r_toCnt <= 10'd0;
        end else if (s_stb_o) begin
            r_toCnt <= r_toCnt + 10'd1;
        end
    end
`else
    assign w_toErr = 1'b0;
`endif

    // Forward the granted master's request to the slave; the bus is quiet while idle.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = 4'h0;
        s_adr_o = 10'h000;
        s_dat_o = 32'h0000_0000;
        case (r_state)
            GNT0: begin
                s_cyc_o = m0_cyc_i;
                s_stb_o = m0_stb_i;
                s_we_o  = m0_we_i;
                s_sel_o = m0_sel_i;
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
            end
            GNT1: begin
                s_cyc_o = m1_cyc_i;
                s_stb_o = m1_stb_i;
                s_we_o  = m1_we_i;
                s_sel_o = m1_sel_i;
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
            end
            default: ;
        endcase
    end

    // Route slave responses to the granted master only; anything arriving while idle is dropped.
    always_comb begin
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        case (r_state)
            GNT0: begin
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i | w_toErr;
            end
            GNT1: begin
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i | w_toErr;
            end
            default: ;
        endcase
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_eth_wb_arbiter.sv
// tb_eth_wb_arbiter: directed scoreboard bench for eth_wb_arbiter.
// Expected output snapshots are queued as each stimulus step is driven and
// popped when the DUT outputs are sampled on the following falling edge.

module tb_eth_wb_arbiter;

    localparam int TO_CYC = 8;
`ifdef ETH_WB_ARB_TIMEOUT_EN
    localparam int STALL_WIN = 30;
`else
    localparam int STALL_WIN = 1000;
`endif

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [3:0]  sel;
        logic [9:0]  adr;
        logic [31:0] dat;
    } mst_t;

    typedef struct packed {
        logic [1:0]  gnt;
        mst_t        s;
        logic        a0;
        logic        e0;
        logic        a1;
        logic        e1;
        logic [31:0] d0;
        logic [31:0] d1;
    } snap_t;

    typedef struct {
        string tag;
        snap_t exp;
    } sb_t;

    sb_t scoreQ[$];
    int  checks = 0;
    int  errors = 0;

    logic        clk;
    logic        rstN;
    mst_t        m0In;
    mst_t        m1In;
    logic [31:0] sDat;
    logic        sAck;
    logic        sErr;

    logic [31:0] m0DatO;
    logic [31:0] m1DatO;
    logic        m0AckO;
    logic        m0ErrO;
    logic        m1AckO;
    logic        m1ErrO;
    logic        sCycO;
    logic        sStbO;
    logic        sWeO;
    logic [3:0]  sSelO;
    logic [9:0]  sAdrO;
    logic [31:0] sDatO;
    logic [1:0]  gntO;

    eth_wb_arbiter #(.TIMEOUT_CYC(TO_CYC)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rstN),
        .m0_cyc_i   (m0In.cyc),
        .m0_stb_i   (m0In.stb),
        .m0_we_i    (m0In.we),
        .m0_sel_i   (m0In.sel),
        .m0_adr_i   (m0In.adr),
        .m0_dat_i   (m0In.dat),
        .m1_cyc_i   (m1In.cyc),
        .m1_stb_i   (m1In.stb),
        .m1_we_i    (m1In.we),
        .m1_sel_i   (m1In.sel),
        .m1_adr_i   (m1In.adr),
        .m1_dat_i   (m1In.dat),
        .m0_dat_o   (m0DatO),
        .m0_ack_o   (m0AckO),
        .m0_err_o   (m0ErrO),
        .m1_dat_o   (m1DatO),
        .m1_ack_o   (m1AckO),
        .m1_err_o   (m1ErrO),
        .s_cyc_o    (sCycO),
        .s_stb_o    (sStbO),
        .s_we_o     (sWeO),
        .s_sel_o    (sSelO),
        .s_adr_o    (sAdrO),
        .s_dat_o    (sDatO),
        .s_dat_i    (sDat),
        .s_ack_i    (sAck),
        .s_err_i    (sErr),
        .gnt_o      (gntO)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model for one sampled cycle: the slave side mirrors whichever master
    // the expected grant names, and both read-data outputs carry the slave data.
    function automatic snap_t expSnap(logic [1:0] gnt, logic a0, logic e0, logic a1, logic e1);
        snap_t r;
        r.gnt = gnt;
        if (gnt == 2'b01) begin
            r.s = m0In;
        end else if (gnt == 2'b10) begin
            r.s = m1In;
        end else begin
            r.s = '0;
        end
        r.a0 = a0;
        r.e0 = e0;
        r.a1 = a1;
        r.e1 = e1;
        r.d0 = sDat;
        r.d1 = sDat;
        return r;
    endfunction

    task automatic setM0(logic cyc, logic stb, logic we, logic [3:0] sel, logic [9:0] adr, logic [31:0] dat);
        m0In = '{cyc, stb, we, sel, adr, dat};
    endtask

    task automatic setM1(logic cyc, logic stb, logic we, logic [3:0] sel, logic [9:0] adr, logic [31:0] dat);
        m1In = '{cyc, stb, we, sel, adr, dat};
    endtask

    // Pop the oldest expectation and compare it with the present DUT outputs.
    task automatic checkOutput();
        snap_t obs;
        sb_t   e;
        obs.gnt   = gntO;
        obs.s.cyc = sCycO;
        obs.s.stb = sStbO;
        obs.s.we  = sWeO;
        obs.s.sel = sSelO;
        obs.s.adr = sAdrO;
        obs.s.dat = sDatO;
        obs.a0    = m0AckO;
        obs.e0    = m0ErrO;
        obs.a1    = m1AckO;
        obs.e1    = m1ErrO;
        obs.d0    = m0DatO;
        obs.d1    = m1DatO;
        checks++;
        if (scoreQ.size() == 0) begin
            errors++;
            $error("[TB] FAIL scoreboard_empty observed=%h required=<queued entry>", obs);
        end else begin
            e = scoreQ.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    // Queue the expectation for the current inputs, let one rising edge pass, sample on the falling edge.
    task automatic applyStimulus(string tag, snap_t exp);
        scoreQ.push_back('{tag, exp});
        @(negedge clk);
        checkOutput();
    endtask

    // Queue and check before any rising edge occurs (combinational / asynchronous behaviour).
    task automatic checkNow(string tag, snap_t exp);
        scoreQ.push_back('{tag, exp});
        #1;
        checkOutput();
    endtask

    initial begin
        logic toErr;
        rstN = 1'b0;
        m0In = '0;
        m1In = '0;
        sDat = 32'h0;
        sAck = 1'b0;
        sErr = 1'b0;

        // Reset: requests and slave responses must not leak through.
        #2;
        setM0(1'b1, 1'b1, 1'b1, 4'hF, 10'h040, 32'hDEAD_BEEF);
        sAck = 1'b1;
        checkNow("reset_gating", expSnap(2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        applyStimulus("reset_hold", expSnap(2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        m0In = '0;
        sAck = 1'b0;
        rstN = 1'b1;
        applyStimulus("idle_after_rst", expSnap(2'b00, 1'b0, 1'b0, 1'b0, 1'b0));

        // m0 alone writes: bus quiet until the next edge, then forwarded.
        setM0(1'b1, 1'b1, 1'b1, 4'hF, 10'h040, 32'hDEAD_BEEF);
        checkNow("m0_req_latency", expSnap(2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        applyStimulus("m0_grant", expSnap(2'b01, 1'b0, 1'b0, 1'b0, 1'b0));
        sAck = 1'b1;
        sDat = 32'hCAFE_F00D;
        applyStimulus("m0_ack", expSnap(2'b01, 1'b1, 1'b0, 1'b0, 1'b0));
        sAck = 1'b0;
        sDat = 32'h0;
        m0In = '0;
        applyStimulus("m0_release", expSnap(2'b00, 1'b0, 1'b0, 1'b0, 1'b0));

        // Fresh reset, then both masters request together: m0 first, direct handoff to m1.
        rstN = 1'b0;
        applyStimulus("reset2", expSnap(2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        rstN = 1'b1;
        setM0(1'b1, 1'b1, 1'b0, 4'h3, 10'h100, 32'h1111_1111);
        setM1(1'b1, 1'b1, 1'b1, 4'hC, 10'h200, 32'h2222_2222);
        applyStimulus("both_req_m0_first", expSnap(2'b01, 1'b0, 1'b0, 1'b0, 1'b0));
        sAck = 1'b1;
        sDat = 32'h0BAD_F00D;
        applyStimulus("both_m0_ack", expSnap(2'b01, 1'b1, 1'b0, 1'b0, 1'b0));
        sAck = 1'b0;
        m0In = '0;
        applyStimulus("handoff_m1", expSnap(2'b10, 1'b0, 1'b0, 1'b0, 1'b0));
        sErr = 1'b1;
        applyStimulus("m1_err_route", expSnap(2'b10, 1'b0, 1'b0, 1'b0, 1'b1));
        sErr = 1'b0;

        // m1 holds the bus through three acked reads while m0 waits.
        setM1(1'b1, 1'b1, 1'b0, 4'hF, 10'h2A0, 32'h0);
        setM0(1'b1, 1'b1, 1'b0, 4'h1, 10'h3FF, 32'h3333_3333);
        for (int i = 0; i < 3; i++) begin
            sAck = 1'b1;
            sDat = 32'hA000_0000 + 32'(i);
            applyStimulus("m1_read_ack", expSnap(2'b10, 1'b0, 1'b0, 1'b1, 1'b0));
            sAck = 1'b0;
            applyStimulus("m1_read_gap", expSnap(2'b10, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        m1In = '0;
        applyStimulus("handoff_m0", expSnap(2'b01, 1'b0, 1'b0, 1'b0, 1'b0));
        m0In = '0;
        applyStimulus("m0_drop_idle", expSnap(2'b00, 1'b0, 1'b0, 1'b0, 1'b0));

        // Round robin: m0 was served last, so a simultaneous request goes to m1.
        setM0(1'b1, 1'b1, 1'b1, 4'h5, 10'h011, 32'h4444_4444);
        setM1(1'b1, 1'b1, 1'b0, 4'hA, 10'h022, 32'h5555_5555);
        applyStimulus("rr_m1", expSnap(2'b10, 1'b0, 1'b0, 1'b0, 1'b0));
        m1In = '0;
        applyStimulus("rr_handoff_m0", expSnap(2'b01, 1'b0, 1'b0, 1'b0, 1'b0));
        m0In = '0;
        applyStimulus("rr_idle", expSnap(2'b00, 1'b0, 1'b0, 1'b0, 1'b0));

        // Slave never answers m0: single error pulse per TO_CYC stalled cycles, or none at all.
        setM0(1'b1, 1'b1, 1'b0, 4'hF, 10'h0F0, 32'h0);
        applyStimulus("stall_grant", expSnap(2'b01, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int i = 1; i <= STALL_WIN; i++) begin
`ifdef ETH_WB_ARB_TIMEOUT_EN
            toErr = ((i % (TO_CYC + 1)) == TO_CYC);
`else
            toErr = 1'b0;
`endif
            applyStimulus("stall_no_ack", expSnap(2'b01, 1'b0, toErr, 1'b0, 1'b0));
        end
        m0In = '0;
        applyStimulus("stall_release", expSnap(2'b00, 1'b0, 1'b0, 1'b0, 1'b0));

        // Slave responses while idle are discarded.
        sAck = 1'b1;
        sErr = 1'b1;
        sDat = 32'h7777_7777;
        applyStimulus("idle_resp_discard", expSnap(2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        sAck = 1'b0;
        sErr = 1'b0;
        sDat = 32'h0;

        // Reset mid-transfer with an ack pending: everything drops at once, stale ack ignored afterwards.
        setM0(1'b1, 1'b1, 1'b1, 4'hF, 10'h055, 32'h8888_8888);
        applyStimulus("mid_grant", expSnap(2'b01, 1'b0, 1'b0, 1'b0, 1'b0));
        sAck = 1'b1;
        rstN = 1'b0;
        checkNow("rst_async_mid", expSnap(2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        m0In = '0;
        applyStimulus("rst_mid_hold", expSnap(2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        rstN = 1'b1;
        applyStimulus("stale_ack_ignored", expSnap(2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        sAck = 1'b0;
        setM1(1'b1, 1'b1, 1'b0, 4'h6, 10'h123, 32'h9999_9999);
        applyStimulus("post_rst_m1_grant", expSnap(2'b10, 1'b0, 1'b0, 1'b0, 1'b0));
        m1In = '0;
        applyStimulus("final_idle", expSnap(2'b00, 1'b0, 1'b0, 1'b0, 1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_wb_arbiter.md
ETH_WB_ARBITER -- requirements
Module: eth_wb_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255: stalled-strobe cycles before forced error; legal range 1..1023.
REQ-002 SHALL have port wb_clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port wb_rst_n_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports m0_cyc_i/m1_cyc_i, m0_stb_i/m1_stb_i, m0_we_i/m1_we_i  input  1 each  master Wishbone controls.
REQ-005 SHALL have ports m0_sel_i/m1_sel_i  input  4; m0_adr_i/m1_adr_i  input  10; m0_dat_i/m1_dat_i  input  32.
REQ-006 SHALL have ports m0_dat_o/m1_dat_o  output  32; m0_ack_o/m1_ack_o, m0_err_o/m1_err_o  output  1 each.
REQ-007 SHALL have ports s_cyc_o, s_stb_o, s_we_o  output  1; s_sel_o  output  4; s_adr_o  output  10; s_dat_o  output  32  to shared Ethernet slave.
REQ-008 SHALL have ports s_dat_i  input  32; s_ack_i, s_err_i  input  1  slave responses.
REQ-009 SHALL have port gnt_o  output  2  one-hot current grant (bit0 = m0, bit1 = m1), 2'b00 when idle.

Function
REQ-010 SHALL implement FSM states IDLE, GNT0, GNT1; state held in registers, reset to IDLE.
REQ-011 SHALL keep last_o register (reset 1) recording the most recently granted master.
REQ-012 In IDLE, one requester (mN_cyc_i=1): SHALL enter GNTN next cycle.
REQ-013 In IDLE, both requesting: SHALL grant the master not equal to last_o (round robin); first grant after reset goes to m0.
REQ-014 In GNTN, SHALL hold the grant while mN_cyc_i=1 regardless of other master's requests; no preemption.
REQ-015 In GNTN, when mN_cyc_i=0: SHALL move directly to the other GNT state if the other master requests, else to IDLE; last_o updated to N.
REQ-016 s_cyc_o/s_stb_o/s_we_o/s_sel_o/s_adr_o/s_dat_o SHALL be combinational copies of the granted master's inputs; all zero in IDLE.
REQ-017 s_ack_i/s_err_i SHALL route only to the granted master; the non-granted master SHALL see ack=0, err=0.
REQ-018 m0_dat_o and m1_dat_o SHALL both equal s_dat_i (broadcast); qualified only by ack.
REQ-019 Request-to-first-s_stb_o latency SHALL be exactly 1 cycle from IDLE; 0 extra cycles on direct handoff (REQ-015).
REQ-020 s_ack_i or s_err_i arriving while IDLE SHALL be discarded.
REQ-021 gnt_o SHALL be registered, one-hot or zero, and never 2'b11.

Reset
REQ-022 wb_rst_n_i low SHALL asynchronously force IDLE, last_o=1, timeout counter=0, gnt_o=0, all s_* outputs 0, all mN_ack_o/mN_err_o 0.
REQ-023 Reset asserted mid-transfer SHALL abandon the transfer; no ack/err delivered after deassertion for that transfer.
REQ-024 First arbitration SHALL occur on the first rising edge after wb_rst_n_i deasserts.

Configuration
REQ-025 Macro ETH_WB_ARB_TIMEOUT_EN defined: SHALL include 10-bit counter incrementing each cycle s_stb_o=1 with s_ack_i=0 and s_err_i=0, clearing on ack/err or grant change.
REQ-026 With ETH_WB_ARB_TIMEOUT_EN, counter reaching TIMEOUT_CYC SHALL pulse the granted master's err_o for exactly one cycle and clear the counter; grant retained until master drops cyc.
REQ-027 Without ETH_WB_ARB_TIMEOUT_EN, no counter SHALL exist; err_o SHALL reflect s_err_i only, stalls last indefinitely.

Verification
REQ-028 m0 alone writes adr 0x040 dat 0xDEADBEEF sel 0xF -> gnt_o=01 after 1 cycle, s_adr_o=0x040, s_dat_o=0xDEADBEEF, m0_ack_o on slave ack, m1_ack_o=0.
REQ-029 m0 and m1 raise cyc same cycle after reset -> m0 granted first; m0 drops cyc -> gnt_o=10 next cycle, no IDLE gap.
REQ-030 m1 holds cyc through 3 acked reads while m0 requests -> gnt_o stays 10 until m1 drops cyc, then 01.
REQ-031 With ETH_WB_ARB_TIMEOUT_EN, TIMEOUT_CYC=8, slave never acks -> m0_err_o single pulse after 8 stalled cycles; without macro, no err over 1000 cycles.
REQ-032 wb_rst_n_i low mid-transfer with s_ack_i pending -> all outputs 0 immediately; after release, stale ack ignored, gnt_o=00 until new request.
